// File: rtl/i2c_mem_slave_burst.sv
// ---------------------------------------------------------------------------
// i2c_mem_slave_burst
//   I2C target with a 7-bit device address and a MEM_DEPTH x 8 register file.
//   The first write byte sets the register pointer. Later bytes are burst
//   writes with pointer auto-increment and wrap. Reads return mem[ptr] and
//   advance the pointer on each master ACK. Repeated START and
//   current-address reads are supported. The slave never stretches SCL.
//
// Parameters
//   DEV_ADDR   7-bit address acknowledged by this slave (default 7'h50)
//   MEM_DEPTH  number of byte locations, 2..256 (default 16)
//
// Ports
//   clk      system clock, at least 8x the SCL rate
//   rst      asynchronous active-low reset; clears the memory and pointer
//   scl      bus clock (input only)
//   sda      open-drain bus data; driven low or released, never driven high
//   busy     high while a transaction addressed to this slave is in progress
//   ack_err  1-cycle pulse when an out-of-range pointer byte is NACKed
//   done     1-cycle pulse on STOP that ends an addressed transaction
//
// Build option
//   I2C_SPIKE_FILTER_EN  when defined, a 3-sample majority filter follows the
//                        synchronisers on scl and sda. Pulses shorter than
//                        2 clk are rejected, and detection latency grows by
//                        2 clk.
// ---------------------------------------------------------------------------
module i2c_mem_slave_burst #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
  output logic busy,
  output logic ack_err,
  output logic done
);

  localparam int              AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [8:0]      DEPTH9 = 9'(MEM_DEPTH);
  localparam logic [AW-1:0]   LAST   = AW'(MEM_DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, PTR, PTRACK, WRDATA, WRACK, RDDATA, RDACK, IGNORE
  } state_t;

  // Bit 1 carries scl and bit 0 carries sda through the same input pipeline.
  // This keeps the two lines aligned, so START and STOP are seen correctly.
  logic [1:0] line_raw;
  logic [1:0] line_f;
  assign line_raw = {scl, sda};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0] sync_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_reg <= 2'b11;
        else      sync_reg <= {sync_reg[0], line_raw[gi]};
      end
`ifdef I2C_SPIKE_FILTER_EN
      logic [2:0] hist_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist_reg <= 3'b111;
        else      hist_reg <= {hist_reg[1:0], sync_reg[1]};
      end
      assign line_f[gi] = (hist_reg[0] & hist_reg[1]) |
                          (hist_reg[0] & hist_reg[2]) |
                          (hist_reg[1] & hist_reg[2]);
`else
      assign line_f[gi] = sync_reg[1];
`endif
    end
  endgenerate

  logic scl_f, sda_f;
  logic scl_prev_reg, sda_prev_reg;
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = line_f[1];
  assign sda_f     = line_f[0];
  assign scl_rise  = scl_f & ~scl_prev_reg;
  assign scl_fall  = ~scl_f & scl_prev_reg;
  assign start_det = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
  assign stop_det  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;

  state_t        state_reg;
  logic [2:0]    bit_cnt_reg;   // wraps 7 -> 0, so each byte starts at 0
  logic [7:0]    shift_reg;
  logic [AW-1:0] ptr_reg;
  logic          rw_reg;
  logic          phase_reg;     // ACK slot: 0 = before drive, 1 = driving
  logic          sda_oe_reg;
  logic [7:0]    mem_reg [MEM_DEPTH];

  logic [7:0]    byte_in;
  logic [AW-1:0] ptr_inc;
  assign byte_in = {shift_reg[6:0], sda_f};
  assign ptr_inc = (ptr_reg == LAST) ? '0 : ptr_reg + AW'(1);

  assign sda = sda_oe_reg ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      ptr_reg      <= '0;
      rw_reg       <= 1'b0;
      phase_reg    <= 1'b0;
      sda_oe_reg   <= 1'b0;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      busy         <= 1'b0;
      ack_err      <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      scl_prev_reg <= scl_f;
      sda_prev_reg <= sda_f;
      ack_err      <= 1'b0;
      done         <= 1'b0;
      if (stop_det) begin
        state_reg  <= IDLE;
        sda_oe_reg <= 1'b0;
        done       <= busy;
        busy       <= 1'b0;
      end else if (start_det) begin
        // A partial byte is simply dropped; the pointer is retained.
        state_reg   <= DEVADDR;
        bit_cnt_reg <= '0;
        sda_oe_reg  <= 1'b0;
      end else begin
        case (state_reg)
          DEVADDR: if (scl_rise) begin
            shift_reg   <= byte_in;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                busy      <= 1'b1;
                rw_reg    <= byte_in[0];
                phase_reg <= 1'b0;
                state_reg <= DEVACK;
              end else begin
                busy      <= 1'b0;
                state_reg <= IGNORE;
              end
            end
          end
          PTR: if (scl_rise) begin
            shift_reg   <= byte_in;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if ({1'b0, byte_in} >= DEPTH9) begin
                ack_err   <= 1'b1;
                state_reg <= IGNORE;
              end else begin
                ptr_reg   <= byte_in[AW-1:0];
                phase_reg <= 1'b0;
                state_reg <= PTRACK;
              end
            end
          end
          WRDATA: if (scl_rise) begin
            shift_reg   <= byte_in;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              mem_reg[ptr_reg] <= byte_in;
              ptr_reg          <= ptr_inc;
              phase_reg        <= 1'b0;
              state_reg        <= WRACK;
            end
          end
          DEVACK, PTRACK, WRACK: if (scl_fall) begin
            // The first fall drives ACK low and the second fall releases it.
            if (!phase_reg) begin
              sda_oe_reg <= 1'b1;
              phase_reg  <= 1'b1;
            end else begin
              sda_oe_reg <= 1'b0;
              if (state_reg == DEVACK && rw_reg) begin
                shift_reg  <= mem_reg[ptr_reg];
                sda_oe_reg <= ~mem_reg[ptr_reg][7];
                state_reg  <= RDDATA;
              end else if (state_reg == DEVACK) begin
                state_reg <= PTR;
              end else begin
                state_reg <= WRDATA;
              end
            end
          end
          RDDATA: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                phase_reg <= 1'b0;
                state_reg <= RDACK;
              end
            end else if (scl_fall) begin
              sda_oe_reg <= ~shift_reg[6];
              shift_reg  <= {shift_reg[6:0], 1'b0};
            end
          end
          RDACK: begin
            if (scl_rise) begin
              if (sda_f) state_reg <= IGNORE;   // master NACK ends the read
              else       ptr_reg   <= ptr_inc;
            end else if (scl_fall) begin
              if (!phase_reg) begin
                sda_oe_reg <= 1'b0;             // free the bus for the master ACK
                phase_reg  <= 1'b1;
              end else begin
                shift_reg  <= mem_reg[ptr_reg];
                sda_oe_reg <= ~mem_reg[ptr_reg][7];
                state_reg  <= RDDATA;
              end
            end
          end
          IDLE, IGNORE: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
